// File: rtl/bcd_converter_hs.sv
// bcd_converter_hs: iterative binary-to-BCD converter (double-dabble).
// Accepts a value on i_Valid & o_Ready, shifts one input bit per cycle with all
// BCD digits adjusted in parallel, then presents a saturated result, its
// significant-digit count and a one-cycle o_DV pulse.
// Build option: define SIGNED_INPUT_EN to treat i_Binary as two's complement
// (magnitude is converted, sign reported on o_Sign); otherwise o_Sign is 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | o_Ready high, waiting for i_Valid
// CONVERT | one double-dabble shift per cycle, INPUT_WIDTH cycles total
// DONE    | load output registers, pulse o_DV, return to IDLE
module bcd_converter_hs #(
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 5
) (
  input  logic                                  i_Clock,
  input  logic                                  i_Reset,
  input  logic [INPUT_WIDTH-1:0]                i_Binary,
  input  logic                                  i_Valid,
  output logic                                  o_Ready,
  output logic [DECIMAL_DIGITS*4-1:0]           o_BCD,
  output logic [$clog2(DECIMAL_DIGITS+1)-1:0]   o_Digits,
  output logic                                  o_Overflow,
  output logic                                  o_Sign,
  output logic                                  o_DV
);

  localparam int BW = DECIMAL_DIGITS * 4;
  localparam int CW = $clog2(INPUT_WIDTH + 1);
  localparam int DW = $clog2(DECIMAL_DIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 state_q;
  logic [INPUT_WIDTH-1:0] bin_q;
  logic [BW-1:0]          bcd_q;
  logic [CW-1:0]          cnt_q;
  logic                   ovf_q;

  logic [BW-1:0]          bcd_out_q;
  logic [DW-1:0]          digits_q;
  logic                   ovf_out_q;
  logic                   dv_q;

  logic [BW-1:0]          adj_bcd;
  logic [BW-1:0]          bcd_d;
  logic                   ovf_d;
  logic [BW-1:0]          res_bcd_d;
  logic [DW-1:0]          res_digits_d;

`ifdef SIGNED_INPUT_EN
  logic                   sign_q;
  logic                   sign_out_q;
  logic                   res_zero;
`endif

  // add-3 correction on every working digit, in parallel
  always_comb begin
    adj_bcd = bcd_q;
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] > 4'd4) adj_bcd[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    end
  end

  assign bcd_d = {adj_bcd[BW-2:0], bin_q[INPUT_WIDTH-1]};
  assign ovf_d = ovf_q | adj_bcd[BW-1];

  // final result: saturate on overflow and count significant digits
  always_comb begin
    res_bcd_d    = ovf_q ? {DECIMAL_DIGITS{4'h9}} : bcd_q;
    res_digits_d = DW'(1);
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] != 4'd0) res_digits_d = DW'(d + 1);
    end
    if (ovf_q) res_digits_d = DW'(DECIMAL_DIGITS);
  end

`ifdef SIGNED_INPUT_EN
  // a zero magnitude never reports a negative sign
  assign res_zero = !ovf_q && (bcd_q == '0);
`endif

  // control FSM with registered result outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_out_q <= '0;
      digits_q  <= '0;
      ovf_out_q <= 1'b0;
      dv_q      <= 1'b0;
`ifdef SIGNED_INPUT_EN
      sign_q     <= 1'b0;
      sign_out_q <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_Valid) begin
`ifdef SIGNED_INPUT_EN
            bin_q  <= i_Binary[INPUT_WIDTH-1] ? -i_Binary : i_Binary;
            sign_q <= i_Binary[INPUT_WIDTH-1];
`else
            bin_q  <= i_Binary;
`endif
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd_q <= bcd_d;
          ovf_q <= ovf_d;
          bin_q <= {bin_q[INPUT_WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(INPUT_WIDTH - 1)) state_q <= S_DONE;
        end
        S_DONE: begin
          bcd_out_q <= res_bcd_d;
          digits_q  <= res_digits_d;
          ovf_out_q <= ovf_q;
`ifdef SIGNED_INPUT_EN
          sign_out_q <= sign_q & ~res_zero;
`endif
          dv_q    <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Ready    = (state_q == S_IDLE);
  assign o_BCD      = bcd_out_q;
  assign o_Digits   = digits_q;
  assign o_Overflow = ovf_out_q;
  assign o_DV       = dv_q;
`ifdef SIGNED_INPUT_EN
  assign o_Sign     = sign_out_q;
`else
  assign o_Sign     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_converter_hs.sv
// Directed bench for bcd_converter_hs: a default instance (16 bit, 5 digits)
// and a 4-digit instance for overflow saturation.
module tb_bcd_converter_hs;

  logic        clk;
  logic        rst;

  logic [15:0] bin5;
  logic        val5;
  logic        rdy5;
  logic [19:0] bcd5;
  logic [2:0]  dig5;
  logic        ovf5;
  logic        sgn5;
  logic        dv5;

  logic [15:0] bin4;
  logic        val4;
  logic        rdy4;
  logic [15:0] bcd4;
  logic [2:0]  dig4;
  logic        ovf4;
  logic        sgn4;
  logic        dv4;

  int cmp_cnt;
  int err_cnt;

  bcd_converter_hs #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Binary(bin5), .i_Valid(val5),
    .o_Ready(rdy5), .o_BCD(bcd5), .o_Digits(dig5), .o_Overflow(ovf5),
    .o_Sign(sgn5), .o_DV(dv5)
  );

  bcd_converter_hs #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(4)) dut4 (
    .i_Clock(clk), .i_Reset(rst), .i_Binary(bin4), .i_Valid(val4),
    .o_Ready(rdy4), .o_BCD(bcd4), .o_Digits(dig4), .o_Overflow(ovf4),
    .o_Sign(sgn4), .o_DV(dv4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one accepted request; lat = edges from accept to o_DV (-1 on timeout)
  task automatic do_conv(input bit w4, input logic [15:0] v,
                         output int lat, output int rdy_bad);
    int n;
    bit got;
    lat = -1;
    rdy_bad = 0;
    n = 0;
    while (!(w4 ? rdy4 : rdy5) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (w4) begin bin4 = v; val4 = 1'b1; end
    else    begin bin5 = v; val5 = 1'b1; end
    @(posedge clk); #1;
    val4 = 1'b0;
    val5 = 1'b0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (w4 ? dv4 : dv5) begin
        got = 1'b1;
        lat = i;
      end else if (w4 ? rdy4 : rdy5) begin
        rdy_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    cmp_cnt++; if (rdy5 !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got %b exp 1", rdy5); end
    cmp_cnt++; if (bcd5 !== 20'h0) begin err_cnt++; $display("FAIL reset_bcd got %h exp 00000", bcd5); end
    cmp_cnt++; if (dig5 !== 3'd0) begin err_cnt++; $display("FAIL reset_digits got %0d exp 0", dig5); end
    cmp_cnt++; if (ovf5 !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf got %b exp 0", ovf5); end
    cmp_cnt++; if (sgn5 !== 1'b0) begin err_cnt++; $display("FAIL reset_sign got %b exp 0", sgn5); end
    cmp_cnt++; if (dv5 !== 1'b0) begin err_cnt++; $display("FAIL reset_dv got %b exp 0", dv5); end
    cmp_cnt++; if (rdy4 !== 1'b1) begin err_cnt++; $display("FAIL reset_ready4 got %b exp 1", rdy4); end
  endtask

  task automatic test_max();
    int lat, rb;
    do_conv(1'b0, 16'd65535, lat, rb);
    cmp_cnt++; if (lat !== 17) begin err_cnt++; $display("FAIL max_latency got %0d exp 17", lat); end
    cmp_cnt++; if (rb !== 0) begin err_cnt++; $display("FAIL max_ready_busy got %0d high cycles exp 0", rb); end
    cmp_cnt++; if (rdy5 !== 1'b1) begin err_cnt++; $display("FAIL max_ready_at_dv got %b exp 1", rdy5); end
    cmp_cnt++; if (bcd5 !== 20'h65535) begin err_cnt++; $display("FAIL max_bcd got %h exp 65535", bcd5); end
    cmp_cnt++; if (dig5 !== 3'd5) begin err_cnt++; $display("FAIL max_digits got %0d exp 5", dig5); end
    cmp_cnt++; if (ovf5 !== 1'b0) begin err_cnt++; $display("FAIL max_ovf got %b exp 0", ovf5); end
    @(posedge clk); #1;
    cmp_cnt++; if (dv5 !== 1'b0) begin err_cnt++; $display("FAIL max_dv_pulse got %b exp 0", dv5); end
  endtask

  task automatic test_patterns();
    logic [15:0] vin [6];
    logic [19:0] vexp [6];
    logic [2:0]  dexp [6];
    int lat, rb;
    vin[0] = 16'd0;     vexp[0] = 20'h00000; dexp[0] = 3'd1;
    vin[1] = 16'd1;     vexp[1] = 20'h00001; dexp[1] = 3'd1;
    vin[2] = 16'd10;    vexp[2] = 20'h00010; dexp[2] = 3'd2;
    vin[3] = 16'd9999;  vexp[3] = 20'h09999; dexp[3] = 3'd4;
    vin[4] = 16'd10000; vexp[4] = 20'h10000; dexp[4] = 3'd5;
    vin[5] = 16'd4095;  vexp[5] = 20'h04095; dexp[5] = 3'd4;
    for (int k = 0; k < 6; k++) begin
      do_conv(1'b0, vin[k], lat, rb);
      cmp_cnt++; if (lat !== 17) begin err_cnt++; $display("FAIL pat%0d_latency got %0d exp 17", k, lat); end
      cmp_cnt++; if (bcd5 !== vexp[k]) begin err_cnt++; $display("FAIL pat%0d_bcd got %h exp %h", k, bcd5, vexp[k]); end
      cmp_cnt++; if (dig5 !== dexp[k]) begin err_cnt++; $display("FAIL pat%0d_digits got %0d exp %0d", k, dig5, dexp[k]); end
      cmp_cnt++; if (ovf5 !== 1'b0) begin err_cnt++; $display("FAIL pat%0d_ovf got %b exp 0", k, ovf5); end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] vin [3];
    logic        oexp [3];
    int lat, rb;
    vin[0] = 16'd12345; oexp[0] = 1'b1;
    vin[1] = 16'd9999;  oexp[1] = 1'b0;
    vin[2] = 16'd10000; oexp[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_conv(1'b1, vin[k], lat, rb);
      cmp_cnt++; if (lat !== 17) begin err_cnt++; $display("FAIL ovf%0d_latency got %0d exp 17", k, lat); end
      cmp_cnt++; if (bcd4 !== 16'h9999) begin err_cnt++; $display("FAIL ovf%0d_bcd got %h exp 9999", k, bcd4); end
      cmp_cnt++; if (ovf4 !== oexp[k]) begin err_cnt++; $display("FAIL ovf%0d_flag got %b exp %b", k, ovf4, oexp[k]); end
      cmp_cnt++; if (dig4 !== 3'd4) begin err_cnt++; $display("FAIL ovf%0d_digits got %0d exp 4", k, dig4); end
    end
  endtask

  task automatic test_back_to_back();
    int first, second, hold_bad, n;
    first = -1;
    second = -1;
    hold_bad = 0;
    n = 0;
    while (!rdy5 && n < 40) begin @(posedge clk); #1; n++; end
    bin5 = 16'd1234;
    val5 = 1'b1;
    @(posedge clk); #1;
    bin5 = 16'd42;
    for (int c = 1; c <= 60 && second < 0; c++) begin
      @(posedge clk); #1;
      if (first >= 0 && c == first + 1) val5 = 1'b0;
      if (dv5) begin
        if (first < 0) begin
          first = c;
          cmp_cnt++; if (bcd5 !== 20'h01234) begin err_cnt++; $display("FAIL b2b_first_bcd got %h exp 01234", bcd5); end
          cmp_cnt++; if (dig5 !== 3'd4) begin err_cnt++; $display("FAIL b2b_first_digits got %0d exp 4", dig5); end
        end else begin
          second = c;
        end
      end else if (first >= 0 && bcd5 !== 20'h01234) begin
        hold_bad++;
      end
    end
    val5 = 1'b0;
    cmp_cnt++; if (first !== 17) begin err_cnt++; $display("FAIL b2b_first_latency got %0d exp 17", first); end
    cmp_cnt++; if (second - first !== 18) begin err_cnt++; $display("FAIL b2b_spacing got %0d exp 18", second - first); end
    cmp_cnt++; if (hold_bad !== 0) begin err_cnt++; $display("FAIL b2b_hold got %0d changed cycles exp 0", hold_bad); end
    cmp_cnt++; if (bcd5 !== 20'h00042) begin err_cnt++; $display("FAIL b2b_second_bcd got %h exp 00042", bcd5); end
    cmp_cnt++; if (dig5 !== 3'd2) begin err_cnt++; $display("FAIL b2b_second_digits got %0d exp 2", dig5); end
  endtask

  task automatic test_reset_abort();
    int dv_seen, lat, rb, n;
    n = 0;
    while (!rdy5 && n < 40) begin @(posedge clk); #1; n++; end
    bin5 = 16'd65535;
    val5 = 1'b1;
    @(posedge clk); #1;
    val5 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    val5 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    val5 = 1'b0;
    cmp_cnt++; if (rdy5 !== 1'b1) begin err_cnt++; $display("FAIL abort_ready got %b exp 1", rdy5); end
    cmp_cnt++; if (bcd5 !== 20'h0) begin err_cnt++; $display("FAIL abort_bcd got %h exp 00000", bcd5); end
    cmp_cnt++; if (dig5 !== 3'd0) begin err_cnt++; $display("FAIL abort_digits got %0d exp 0", dig5); end
    cmp_cnt++; if (ovf4 !== 1'b0) begin err_cnt++; $display("FAIL abort_ovf4 got %b exp 0", ovf4); end
    dv_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (dv5 || !rdy5) dv_seen++;
    end
    cmp_cnt++; if (dv_seen !== 0) begin err_cnt++; $display("FAIL abort_no_dv got %0d active cycles exp 0", dv_seen); end
    do_conv(1'b0, 16'd100, lat, rb);
    cmp_cnt++; if (lat !== 17) begin err_cnt++; $display("FAIL abort_next_latency got %0d exp 17", lat); end
    cmp_cnt++; if (bcd5 !== 20'h00100) begin err_cnt++; $display("FAIL abort_next_bcd got %h exp 00100", bcd5); end
    cmp_cnt++; if (dig5 !== 3'd3) begin err_cnt++; $display("FAIL abort_next_digits got %0d exp 3", dig5); end
  endtask

  task automatic test_sign();
    logic [15:0] vin [4];
    logic [19:0] vexp [4];
    logic        sexp [4];
    int lat, rb;
    vin[0] = 16'h8000; vin[1] = 16'hFFFF; vin[2] = 16'h0000; vin[3] = 16'h0005;
`ifdef SIGNED_INPUT_EN
    vexp[0] = 20'h32768; sexp[0] = 1'b1;
    vexp[1] = 20'h00001; sexp[1] = 1'b1;
`else
    vexp[0] = 20'h32768; sexp[0] = 1'b0;
    vexp[1] = 20'h65535; sexp[1] = 1'b0;
`endif
    vexp[2] = 20'h00000; sexp[2] = 1'b0;
    vexp[3] = 20'h00005; sexp[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_conv(1'b0, vin[k], lat, rb);
      cmp_cnt++; if (bcd5 !== vexp[k]) begin err_cnt++; $display("FAIL sign%0d_bcd got %h exp %h", k, bcd5, vexp[k]); end
      cmp_cnt++; if (sgn5 !== sexp[k]) begin err_cnt++; $display("FAIL sign%0d_sign got %b exp %b", k, sgn5, sexp[k]); end
    end
    do_conv(1'b1, 16'h8000, lat, rb);
    cmp_cnt++; if (bcd4 !== 16'h9999) begin err_cnt++; $display("FAIL sign_sat_bcd got %h exp 9999", bcd4); end
    cmp_cnt++; if (ovf4 !== 1'b1) begin err_cnt++; $display("FAIL sign_sat_ovf got %b exp 1", ovf4); end
`ifdef SIGNED_INPUT_EN
    cmp_cnt++; if (sgn4 !== 1'b1) begin err_cnt++; $display("FAIL sign_sat_sign got %b exp 1", sgn4); end
`else
    cmp_cnt++; if (sgn4 !== 1'b0) begin err_cnt++; $display("FAIL sign_sat_sign got %b exp 0", sgn4); end
`endif
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    rst  = 1'b1;
    bin5 = '0; val5 = 1'b0;
    bin4 = '0; val4 = 1'b0;
    test_reset();
    test_max();
    test_patterns();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_sign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
